rtc_lectura_bus: RTL
====================

// Module: rtc_lectura_bus
// PURPOSE
// Reader side of the RTC multiplexed A/D bus. On each start request it sweeps all nine time, date and timer registers of the RTC.
// It captures the BCD bytes and commits them together to the display and datapath, so every field comes from the same sweep.
// Field index uses the direccion encoding of the control FSM:
// 0 hora, 1 min, 2 seg, 3 dia, 4 mes, 5 anno, 6 temp_hora, 7 temp_min, 8 temp_seg.
// PARAMETERS
// T_STB    4      cycles a strobe (wr_n/rd_n with cs_n) is held low per bus phase, >=2
// T_GAP    2      cycles all strobes are high between phases, >=1
// CMD_EN   1      1: prefix each sweep with a latch-command write cycle
// CMD_ADDR 8'hF0  address of the latch command
// CMD_DATA 8'hF0  data written by the latch command
// PORTS
// clk       in  1  system clock
// reset     in  1  asynchronous, active-low reset
// start     in  1  sweep request, sampled in IDLE only
// hold      in  1  1 = block new sweeps and suppress commit (clock/timer programming active)
// ad_in     in  8  bus data from the RTC
// ad_out    out 8  bus address/data driven to the RTC
// ad_oe     out 1  1 = FPGA drives the bus
// ad_sel    out 1  0 = address phase, 1 = data phase (A/D pin)
// cs_n, rd_n, wr_n  out 1 each  RTC strobes, active low
// busy      out 1  sweep in progress
// done      out 1  one-cycle pulse when a sweep ends
// bcd_err   out 1  valid with done; 1 = at least one captured byte was not valid BCD
// field_idx out 4  field currently being read (direccion encoding)
// dia, mes, anno, hora, minutos, segundos, temp_hora, temp_min, temp_seg  out 8 each  committed BCD values
// BEHAVIOUR
// - All outputs are registered.
// - Reset values:
//   - strobes and ad_sel = 1; ad_oe, busy, done, bcd_err = 0; ad_out = 0; field_idx = 0.
//   - dia = mes = 8'h01; all other fields 8'h00.
//   - Shadow registers are cleared the same way.
// - FSM: IDLE -> [CMD_A -> CMD_D] -> {ADDR -> RDAT} x9 -> COMMIT -> IDLE.
// - Each bus phase is T_STB cycles of strobe followed by T_GAP cycles of gap, so one phase = T_STB+T_GAP cycles.
// - IDLE:
//   - start=1 and hold=0 at an edge -> busy=1 from that edge.
//   - The first phase's outputs are valid from the same edge.
// - Write phases (CMD_A, CMD_D, ADDR):
//   - cs_n = 0, wr_n = 0, ad_oe = 1 during the strobe.
//   - ad_sel = 0 for the address byte, 1 for the data byte.
// - RDAT phase:
//   - cs_n = 0, rd_n = 0, ad_sel = 1, ad_oe = 0.
//   - ad_in is sampled into the shadow register on the last strobe cycle.
// - During the gap: cs_n = rd_n = wr_n = 1 and ad_oe = 0.
// - ad_out holds its last value through the gap.
// - Read order is fixed by field_idx 0..8, with RTC addresses:
//   hora 23h, min 22h, seg 21h, dia 24h, mes 25h, anno 26h, temp_hora 43h, temp_min 42h, temp_seg 41h.
// - BCD check: a nibble > 9 sets the sweep's error flag. That field keeps its previous committed value; all other fields commit normally.
// - COMMIT (one cycle):
//   - done = 1; bcd_err = error flag; busy = 0.
//   - Valid shadow bytes are copied to the outputs only if hold = 0 in this cycle.
//   - If hold = 1, done still pulses and the committed values are unchanged.
// - Latency from the start edge to the done cycle: (2*CMD_EN + 18)*(T_STB+T_GAP) cycles.
//   With defaults this is 120 cycles.
// - start while busy is ignored (not queued).
// - start held high re-triggers on the cycle after done.
// - hold going high mid-sweep does not abort the sweep; it only gates the commit.
// - Reset mid-sweep: strobes are released on the reset edge and no partial data is committed.
// - field_idx counts 0..8 and returns to 0 in IDLE; it never exceeds 8.
// TESTING
// 1. Reset low then release, no start -> strobes high, dia = mes = 01, other fields 00, busy = 0.
// 2. RTC model returns 23:59:58 on 31/12/99 with timer 01:02:03, start pulse ->
//    done exactly 120 cycles later and all nine fields match.
// 3. Model returns 8'h3A for minutos ->
//    bcd_err = 1 with done, minutos keeps its old value, other fields update.
// 4. hold = 1 at COMMIT -> done pulses, outputs unchanged.
//    hold = 1 in IDLE with start -> no sweep, busy stays 0.
// 5. Reset asserted at cycle 50 of a sweep ->
//    cs_n, rd_n, wr_n = 1 immediately and fields stay at reset values.
// 6. CMD_EN = 0, T_STB = 2, T_GAP = 1 ->
//    first phase is an address write of 23h, done after 54 cycles, start pulses during busy are ignored.

Source files
------------

// File: rtl/rtc_lectura_bus_if.sv
// Multiplexed A/D bus between the FPGA reader (master) and the RTC (slave).
interface rtc_lectura_bus_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       ad_sel;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;

    modport master (input ad_in, output ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n);
    modport slave  (output ad_in, input ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n);
endinterface

// File: rtl/rtc_lectura_bus.sv
// RTC bus reader: sweeps the nine time/date/timer registers and commits all
// valid BCD bytes together so every displayed field comes from one sweep.

// Per-field shadow/commit slot; one instance per direccion index.
module rtc_lectura_campo #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cap_i,
    input  logic       ok_i,
    input  logic       commit_i,
    input  logic [7:0] byte_i,
    output logic [7:0] val_o
);
    logic [7:0] shadow_q, val_q;
    logic       ok_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= RST_VAL;
            ok_q     <= 1'b0;
            val_q    <= RST_VAL;
        end else begin
            if (cap_i) begin
                shadow_q <= byte_i;
                ok_q     <= ok_i;
            end
            if (commit_i && ok_q) val_q <= shadow_q;
        end
    end

    assign val_o = val_q;
endmodule

module rtc_lectura_bus #(
    parameter int         T_STB    = 4,
    parameter int         T_GAP    = 2,
    parameter bit         CMD_EN   = 1'b1,
    parameter logic [7:0] CMD_ADDR = 8'hF0,
    parameter logic [7:0] CMD_DATA = 8'hF0
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    input  logic                    hold_i,
    rtc_lectura_bus_if.master       bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    bcd_err_o,
    output logic [3:0]              field_idx_o,
    output logic [7:0]              hora_o,
    output logic [7:0]              minutos_o,
    output logic [7:0]              segundos_o,
    output logic [7:0]              dia_o,
    output logic [7:0]              mes_o,
    output logic [7:0]              anno_o,
    output logic [7:0]              temp_hora_o,
    output logic [7:0]              temp_min_o,
    output logic [7:0]              temp_seg_o
);
    localparam int P  = T_STB + T_GAP;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(T_STB - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD_A, S_CMD_D, S_ADDR, S_RDAT, S_COMMIT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    fidx_q, fidx_d;
    logic          err_q, err_d;
    logic          cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic          ad_oe_q, ad_oe_d, ad_sel_q, ad_sel_d;
    logic [7:0]    ad_out_q, ad_out_d;
    logic          busy_q, busy_d, done_q, done_d, bcd_err_q, bcd_err_d;
    logic          phase_end, cap, bad, strobe, in_phase, wr_phase, commit;

    function automatic logic [7:0] addr_of(input logic [3:0] f);
        case (f)
            4'd0:    addr_of = 8'h23;
            4'd1:    addr_of = 8'h22;
            4'd2:    addr_of = 8'h21;
            4'd3:    addr_of = 8'h24;
            4'd4:    addr_of = 8'h25;
            4'd5:    addr_of = 8'h26;
            4'd6:    addr_of = 8'h43;
            4'd7:    addr_of = 8'h42;
            4'd8:    addr_of = 8'h41;
            default: addr_of = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fidx_d    = fidx_q;
        err_d     = err_q;
        phase_end = (cnt_q == CNT_LAST);
        cap       = (state_q == S_RDAT) && (cnt_q == STB_LAST);
        bad       = (bus.ad_in[7:4] > 4'd9) || (bus.ad_in[3:0] > 4'd9);
        if (cap && bad) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                fidx_d = '0;
                cnt_d  = '0;
                if (start_i && !hold_i) begin
                    state_d = CMD_EN ? S_CMD_A : S_ADDR;
                    err_d   = 1'b0;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                fidx_d  = '0;
                cnt_d   = '0;
            end
            default: begin
                cnt_d = phase_end ? '0 : cnt_q + CW'(1);
                if (phase_end) begin
                    case (state_q)
                        S_CMD_A: state_d = S_CMD_D;
                        S_CMD_D: state_d = S_ADDR;
                        S_ADDR:  state_d = S_RDAT;
                        default: begin
                            if (fidx_q == 4'd8) state_d = S_COMMIT;
                            else begin
                                state_d = S_ADDR;
                                fidx_d  = fidx_q + 4'd1;
                            end
                        end
                    endcase
                end
            end
        endcase

        // Bus outputs are decoded from the next state so they land registered
        // on the same edge the state changes.
        strobe   = (cnt_d <= STB_LAST);
        in_phase = state_d inside {S_CMD_A, S_CMD_D, S_ADDR, S_RDAT};
        wr_phase = state_d inside {S_CMD_A, S_CMD_D, S_ADDR};
        cs_n_d   = !(in_phase && strobe);
        wr_n_d   = !(wr_phase && strobe);
        rd_n_d   = !((state_d == S_RDAT) && strobe);
        ad_oe_d  = wr_phase && strobe;
        ad_sel_d = !((state_d == S_CMD_A) || (state_d == S_ADDR));
        ad_out_d = ad_out_q;
        case (state_d)
            S_CMD_A: ad_out_d = CMD_ADDR;
            S_CMD_D: ad_out_d = CMD_DATA;
            S_ADDR:  ad_out_d = addr_of(fidx_d);
            default: ad_out_d = ad_out_q;
        endcase
        busy_d    = in_phase;
        done_d    = (state_d == S_COMMIT);
        bcd_err_d = done_d && err_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            fidx_q    <= '0;
            err_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_oe_q   <= 1'b0;
            ad_sel_q  <= 1'b1;
            ad_out_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fidx_q    <= fidx_d;
            err_q     <= err_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            ad_oe_q   <= ad_oe_d;
            ad_sel_q  <= ad_sel_d;
            ad_out_q  <= ad_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_err_q <= bcd_err_d;
        end
    end

    // Commit lands on the edge that closes the COMMIT cycle, gated by hold then.
    assign commit = (state_q == S_COMMIT) && !hold_i;

    logic [8:0][7:0] fld;

    for (genvar i = 0; i < 9; i++) begin : g_campo
        rtc_lectura_campo #(
            .RST_VAL((i == 3 || i == 4) ? 8'h01 : 8'h00)
        ) u_campo (
            .clk_i    (clk_i),
            .rst_ni   (reset_ni),
            .cap_i    (cap && (fidx_q == 4'(i))),
            .ok_i     (!bad),
            .commit_i (commit),
            .byte_i   (bus.ad_in),
            .val_o    (fld[i])
        );
    end

    assign bus.ad_out  = ad_out_q;
    assign bus.ad_oe   = ad_oe_q;
    assign bus.ad_sel  = ad_sel_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.wr_n    = wr_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign bcd_err_o   = bcd_err_q;
    assign field_idx_o = fidx_q;
    assign hora_o      = fld[0];
    assign minutos_o   = fld[1];
    assign segundos_o  = fld[2];
    assign dia_o       = fld[3];
    assign mes_o       = fld[4];
    assign anno_o      = fld[5];
    assign temp_hora_o = fld[6];
    assign temp_min_o  = fld[7];
    assign temp_seg_o  = fld[8];
endmodule
